cpu_isu: RTL

- Issue stage feeding cpu_exu. Accepts one decoded instruction per cycle from the decode stage and reads the integer and FP register files.
- Checks a scoreboard for RAW and WAW hazards, then drives the registered operand and control bundle that the EXU consumes.
- When nothing can issue, drives a bubble (wait_exe=1).
- Scoreboard bits clear on writeback-stage retirement.

---
 rtl/cpu_isu_pkg.sv | 20 ++
 rtl/cpu_isu_if.sv | 31 +++
 rtl/cpu_isu_scoreboard.sv | 39 +++
 rtl/cpu_isu.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_isu_pkg.sv
// Shared definitions for the issue stage: EXU operation-class codes,
// source bit positions in id_use_rs/id_rs_fp, and destination tracking rule.
package cpu_isu_pkg;

    typedef enum logic [1:0] {
        INT  = 2'b00,
        FP_S = 2'b01,
        FP_D = 2'b10
    } fp_ctrl_e;

    localparam int ISU_SRC1 = 0;
    localparam int ISU_SRC2 = 1;
    localparam int ISU_SRC3 = 2;

    // x0 is architecturally constant, so writes to it never occupy the scoreboard.
    function automatic logic dest_tracked(input logic [4:0] rd, input logic rd_fp);
        return !(rd == 5'd0 && !rd_fp);
    endfunction

endpackage

// File: rtl/cpu_isu_if.sv
// Decode-to-issue handshake and decoded instruction bundle.
interface cpu_isu_if;

    logic       id_valid;
    logic       id_ready;
    logic [1:0] id_fp_ctrl;
    logic [4:0] id_alu_ctrl;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rs3;
    logic [2:0] id_use_rs;
    logic [2:0] id_rs_fp;
    logic       id_use_imm;
    logic [31:0] id_imm;
    logic [4:0] id_rd;
    logic       id_rd_fp;
    logic       id_rd_we;

    modport master (
        output id_valid, id_fp_ctrl, id_alu_ctrl, id_rs1, id_rs2, id_rs3,
               id_use_rs, id_rs_fp, id_use_imm, id_imm, id_rd, id_rd_fp, id_rd_we,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_fp_ctrl, id_alu_ctrl, id_rs1, id_rs2, id_rs3,
               id_use_rs, id_rs_fp, id_use_imm, id_imm, id_rd, id_rd_fp, id_rd_we,
        output id_ready
    );

endinterface

// File: rtl/cpu_isu_scoreboard.sv
// One register file's busy vector: set on issue, clear on retirement, wipe on flush.
// A same-cycle set and clear of one entry leaves it busy.
module isu_scoreboard #(
    parameter int REG_NUM   = 32,
    parameter bit ZERO_HARD = 1'b0,
    parameter int IDX_W     = $clog2(REG_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               set_en,
    input  logic [IDX_W-1:0]   set_idx,
    input  logic               clr_en,
    input  logic [IDX_W-1:0]   clr_idx,
    output logic [REG_NUM-1:0] busy
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_nxt;
    logic [REG_NUM-1:0] zero_mask;

    assign zero_mask = {{(REG_NUM-1){1'b1}}, ~ZERO_HARD};

    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        if (flush)  busy_nxt = '0;
        busy_nxt = busy_nxt & zero_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_nxt;
    end

    assign busy = busy_q & zero_mask;

endmodule

// File: rtl/cpu_isu.sv
// Issue stage: scoreboard hazard check, operand selection from the INT/FP
// register files, and the registered operand/control bundle for the EXU.
module cpu_isu
    import cpu_isu_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int FP_W    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_flag,
    cpu_isu_if.slave        dec,
    input  logic [31:0]     int_rdata1,
    input  logic [31:0]     int_rdata2,
    input  logic [FP_W-1:0] fp_rdata1,
    input  logic [FP_W-1:0] fp_rdata2,
    input  logic [FP_W-1:0] fp_rdata3,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            wb_fp,
    output logic [1:0]      fp_ctrl,
    output logic [4:0]      alu_ctrl,
    output logic [FP_W-1:0] in1,
    output logic [FP_W-1:0] in2,
    output logic [FP_W-1:0] in3,
    output logic            wait_exe,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_fp,
    output logic            ex_rd_we
);

    localparam int IDX_W = $clog2(REG_NUM);

    logic [REG_NUM-1:0] busy_int;
    logic [REG_NUM-1:0] busy_fp;
    logic [2:0]         hz_src;
    logic               hz_waw;
    logic               hz;
    logic               vld_p0;
    logic               set_int;
    logic               set_fp;
    logic [FP_W-1:0]    opnd1_p0;
    logic [FP_W-1:0]    opnd2_p0;
    logic [FP_W-1:0]    opnd3_p0;

    // Hazard detection and handshake (combinational)
    always_comb begin
        hz_src[ISU_SRC1] = dec.id_use_rs[ISU_SRC1] &&
            (dec.id_rs_fp[ISU_SRC1] ? busy_fp[dec.id_rs1] : busy_int[dec.id_rs1]);
        hz_src[ISU_SRC2] = dec.id_use_rs[ISU_SRC2] &&
            (dec.id_rs_fp[ISU_SRC2] ? busy_fp[dec.id_rs2] : busy_int[dec.id_rs2]);
        hz_src[ISU_SRC3] = dec.id_use_rs[ISU_SRC3] &&
            (dec.id_rs_fp[ISU_SRC3] ? busy_fp[dec.id_rs3] : busy_int[dec.id_rs3]);
        hz_waw = dec.id_rd_we &&
            (dec.id_rd_fp ? busy_fp[dec.id_rd] : busy_int[dec.id_rd]);
        hz = (|hz_src) || hz_waw;
    end

    assign dec.id_ready = !hz && !flush_flag;
    assign vld_p0       = dec.id_valid && dec.id_ready;

    assign set_int = vld_p0 && dec.id_rd_we && !dec.id_rd_fp &&
                     dest_tracked(dec.id_rd, dec.id_rd_fp);
    assign set_fp  = vld_p0 && dec.id_rd_we && dec.id_rd_fp;

    isu_scoreboard #(.REG_NUM(REG_NUM), .ZERO_HARD(1'b1)) u_sb_int (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_flag),
        .set_en  (set_int),
        .set_idx (dec.id_rd[IDX_W-1:0]),
        .clr_en  (wb_valid && !wb_fp),
        .clr_idx (wb_rd[IDX_W-1:0]),
        .busy    (busy_int)
    );

    isu_scoreboard #(.REG_NUM(REG_NUM), .ZERO_HARD(1'b0)) u_sb_fp (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_flag),
        .set_en  (set_fp),
        .set_idx (dec.id_rd[IDX_W-1:0]),
        .clr_en  (wb_valid && wb_fp),
        .clr_idx (wb_rd[IDX_W-1:0]),
        .busy    (busy_fp)
    );

    // Operand selection; FP_S operands keep their upper bits as read.
    always_comb begin
        opnd1_p0 = dec.id_rs_fp[ISU_SRC1] ? fp_rdata1
                                          : {{(FP_W-32){1'b0}}, int_rdata1};
        if (dec.id_use_imm)
            opnd2_p0 = {{(FP_W-32){1'b0}}, dec.id_imm};
        else if (dec.id_rs_fp[ISU_SRC2])
            opnd2_p0 = fp_rdata2;
        else
            opnd2_p0 = {{(FP_W-32){1'b0}}, int_rdata2};
        opnd3_p0 = dec.id_rs_fp[ISU_SRC3] ? fp_rdata3 : '0;
    end

    // Stage boundary: issue -> EXU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_exe <= 1'b1;
            fp_ctrl  <= '0;
            alu_ctrl <= '0;
            in1      <= '0;
            in2      <= '0;
            in3      <= '0;
            ex_rd    <= '0;
            ex_rd_fp <= 1'b0;
            ex_rd_we <= 1'b0;
        end else if (vld_p0) begin
            wait_exe <= 1'b0;
            fp_ctrl  <= dec.id_fp_ctrl;
            alu_ctrl <= dec.id_alu_ctrl;
            in1      <= opnd1_p0;
            in2      <= opnd2_p0;
            in3      <= opnd3_p0;
            ex_rd    <= dec.id_rd;
            ex_rd_fp <= dec.id_rd_fp;
            ex_rd_we <= dec.id_rd_we;
        end else begin
            wait_exe <= 1'b1;
            fp_ctrl  <= '0;
            alu_ctrl <= '0;
            in1      <= '0;
            in2      <= '0;
            in3      <= '0;
            ex_rd    <= '0;
            ex_rd_fp <= 1'b0;
            ex_rd_we <= 1'b0;
        end
    end

endmodule
